// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite widths, response codes and master-read state type
package axil_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    MR_IDLE,
    MR_AR,
    MR_R_WAIT,
    MR_RSP,
    MR_DRAIN
  } mr_state_e;

endpackage

// File: rtl/axi_lite_master_read_if.sv
// rtl/axi_lite_master_read_if.sv - user command/response port plus AXI4-Lite AR/R pins of the read master
interface axi_lite_master_read_if import axil_pkg::*; ();

  logic              user_cmd_valid;
  logic              user_cmd_ready;
  logic [ADDR_W-1:0] user_cmd_addr;
  logic              user_rsp_valid;
  logic              user_rsp_ready;
  logic [DATA_W-1:0] user_rsp_data;
  logic [1:0]        user_rsp_resp;
  logic              user_rsp_timeout;

  logic              M_AXIL_ARVALID;
  logic              M_AXIL_ARREADY;
  logic [ADDR_W-1:0] M_AXIL_ARADDR;
  logic [2:0]        M_AXIL_ARPROT;
  logic              M_AXIL_RVALID;
  logic              M_AXIL_RREADY;
  logic [DATA_W-1:0] M_AXIL_RDATA;
  logic [1:0]        M_AXIL_RRESP;

  modport master (
    input  user_cmd_valid, user_cmd_addr, user_rsp_ready,
           M_AXIL_ARREADY, M_AXIL_RVALID, M_AXIL_RDATA, M_AXIL_RRESP,
    output user_cmd_ready, user_rsp_valid, user_rsp_data, user_rsp_resp, user_rsp_timeout,
           M_AXIL_ARVALID, M_AXIL_ARADDR, M_AXIL_ARPROT, M_AXIL_RREADY
  );

  modport slave (
    output user_cmd_valid, user_cmd_addr, user_rsp_ready,
           M_AXIL_ARREADY, M_AXIL_RVALID, M_AXIL_RDATA, M_AXIL_RRESP,
    input  user_cmd_ready, user_rsp_valid, user_rsp_data, user_rsp_resp, user_rsp_timeout,
           M_AXIL_ARVALID, M_AXIL_ARADDR, M_AXIL_ARPROT, M_AXIL_RREADY
  );

endinterface

// File: rtl/axil_timeout_cnt.sv
// rtl/axil_timeout_cnt.sv - saturating wait counter that flags expiry after TIMEOUT enabled cycles
module axil_timeout_cnt #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    assign expire = 1'b0;
  end else begin : g_on
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    // count reads k in the k-th enabled cycle after clear, so expire is seen TIMEOUT cycles in
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        count <= '0;
      end else if (enable && count != LIMIT) begin
        count <= count + 1'b1;
      end
    end

    assign expire = enable && (count == LIMIT);
  end

endmodule

// File: rtl/axi_lite_master_read.sv
// rtl/axi_lite_master_read.sv - single-outstanding AXI4-Lite read master with misalign check and R timeout/drain
module axi_lite_master_read import axil_pkg::*; #(
  parameter logic [2:0] ARPROT_VAL = 3'b000,
  parameter int         TIMEOUT    = 256
) (
  input logic M_AXIL_ACLK,
  input logic M_AXIL_ARESET,
  axi_lite_master_read_if.master bus
);

  mr_state_e         state;
  logic              cmd_ready;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              rready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_resp;
  logic              rsp_timeout;
  logic              drain_pending;
  logic              tmo_clear;
  logic              tmo_enable;
  logic              tmo_expire;

  assign tmo_clear  = (state == MR_AR) && bus.M_AXIL_ARREADY;
  assign tmo_enable = (state == MR_R_WAIT);

  axil_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (M_AXIL_ACLK),
    .rst    (M_AXIL_ARESET),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expire (tmo_expire)
  );

  always_ff @(posedge M_AXIL_ACLK) begin
    if (M_AXIL_ARESET) begin
      state         <= MR_IDLE;
      cmd_ready     <= 1'b0;
      arvalid       <= 1'b0;
      araddr        <= '0;
      rready        <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_resp      <= RESP_OKAY;
      rsp_timeout   <= 1'b0;
      drain_pending <= 1'b0;
    end else begin
      case (state)
        MR_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_ready && bus.user_cmd_valid) begin
            cmd_ready <= 1'b0;
            if (bus.user_cmd_addr[1:0] == 2'b00) begin
              araddr  <= bus.user_cmd_addr;
              arvalid <= 1'b1;
              state   <= MR_AR;
            end else begin
              rsp_data    <= '0;
              rsp_resp    <= RESP_SLVERR;
              rsp_timeout <= 1'b0;
              rsp_valid   <= 1'b1;
              state       <= MR_RSP;
            end
          end
        end
        MR_AR: begin
          if (bus.M_AXIL_ARREADY) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= MR_R_WAIT;
          end
        end
        MR_R_WAIT: begin
          // a beat arriving in the expiry cycle takes priority over the synthesised error
          if (bus.M_AXIL_RVALID) begin
            rready      <= 1'b0;
            rsp_data    <= bus.M_AXIL_RDATA;
            rsp_resp    <= bus.M_AXIL_RRESP;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= MR_RSP;
          end else if (tmo_expire) begin
            rready        <= 1'b0;
            rsp_data      <= '0;
            rsp_resp      <= RESP_SLVERR;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            drain_pending <= 1'b1;
            state         <= MR_RSP;
          end
        end
        MR_RSP: begin
          if (bus.user_rsp_ready) begin
            rsp_valid <= 1'b0;
            if (drain_pending) begin
              rready <= 1'b1;
              state  <= MR_DRAIN;
            end else begin
              cmd_ready <= 1'b1;
              state     <= MR_IDLE;
            end
          end
        end
        MR_DRAIN: begin
          if (bus.M_AXIL_RVALID) begin
            rready        <= 1'b0;
            drain_pending <= 1'b0;
            cmd_ready     <= 1'b1;
            state         <= MR_IDLE;
          end
        end
        default: state <= MR_IDLE;
      endcase
    end
  end

  assign bus.user_cmd_ready   = cmd_ready;
  assign bus.user_rsp_valid   = rsp_valid;
  assign bus.user_rsp_data    = rsp_data;
  assign bus.user_rsp_resp    = rsp_resp;
  assign bus.user_rsp_timeout = rsp_timeout;
  assign bus.M_AXIL_ARVALID   = arvalid;
  assign bus.M_AXIL_ARADDR    = araddr;
  assign bus.M_AXIL_ARPROT    = ARPROT_VAL;
  assign bus.M_AXIL_RREADY    = rready;

endmodule

// File: tb/tb_axi_lite_master_read.sv
// tb/tb_axi_lite_master_read.sv - self-checking bench for axi_lite_master_read
module tb_axi_lite_master_read;
  import axil_pkg::*;

  localparam int         TMO  = 8;
  localparam logic [2:0] PROT = 3'b010;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        tmo;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    int          ard;
    int          rd;
    logic [31:0] d;
    logic [1:0]  r;
    int          hold;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  rsp_t        exp_q[$];
  int          ar_delay, r_delay;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [31:0] cur_addr;
  int          ar_hs = 0, r_hs = 0, av_cycles = 0, last_r_hs_cyc = 0;

  axi_lite_master_read_if bus ();

  axi_lite_master_read #(.ARPROT_VAL(PROT), .TIMEOUT(TMO)) dut (
    .M_AXIL_ACLK   (clk),
    .M_AXIL_ARESET (rst),
    .bus           (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected user response from the transaction rules alone: misaligned -> SLVERR,
  // beat later than the TIMEOUT-th R_WAIT cycle -> synthesised SLVERR, otherwise pass-through.
  function automatic rsp_t predict(input logic [31:0] a, input int rd, input logic [31:0] d, input logic [1:0] r);
    rsp_t e;
    if (a[1:0] != 2'b00)          e = '{32'h0, RESP_SLVERR, 1'b0};
    else if (TMO != 0 && rd > TMO) e = '{32'h0, RESP_SLVERR, 1'b1};
    else                          e = '{d, r, 1'b0};
    return e;
  endfunction

  // Slave model: ARREADY after ar_delay waiting cycles; one beat offered from offset r_delay after the AR handshake.
  initial begin
    int   r_off;
    int   ar_wait;
    logic beat_armed;
    r_off = 0; ar_wait = 0; beat_armed = 1'b0;
    bus.M_AXIL_ARREADY = 1'b0;
    bus.M_AXIL_RVALID  = 1'b0;
    bus.M_AXIL_RDATA   = 32'h0;
    bus.M_AXIL_RRESP   = 2'b00;
    forever begin
      @(posedge clk); #1;
      bus.M_AXIL_ARREADY = bus.M_AXIL_ARVALID && (ar_wait >= ar_delay);
      bus.M_AXIL_RVALID  = beat_armed && (r_off >= r_delay);
      bus.M_AXIL_RDATA   = bus.M_AXIL_RVALID ? s_rdata : 32'h0;
      bus.M_AXIL_RRESP   = s_rresp;
      @(negedge clk);
      if (rst) begin
        beat_armed = 1'b0;
        ar_wait    = 0;
      end else begin
        if (bus.M_AXIL_ARVALID) av_cycles++;
        if (bus.M_AXIL_ARVALID && bus.M_AXIL_ARREADY) begin
          ar_hs++;
          ar_wait    = 0;
          beat_armed = 1'b1;
          r_off      = 0;
        end else begin
          if (bus.M_AXIL_ARVALID) ar_wait++;
          if (beat_armed) r_off++;
        end
        if (bus.M_AXIL_RVALID && bus.M_AXIL_RREADY) begin
          r_hs++;
          last_r_hs_cyc = cyc;
          beat_armed    = 1'b0;
        end
      end
    end
  end

  // Compare process: AR stability/address and every cycle of a presented response against the model queue.
  initial begin
    logic        prev_wait;
    logic [31:0] prev_addr;
    prev_wait = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wait = 1'b0;
      end else begin
        if (bus.M_AXIL_ARVALID) begin
          check("araddr", bus.M_AXIL_ARADDR, cur_addr);
          check("arprot", 32'(bus.M_AXIL_ARPROT), 32'(PROT));
        end
        if (prev_wait) begin
          check("arvalid_hold", 32'(bus.M_AXIL_ARVALID), 32'd1);
          check("araddr_hold", bus.M_AXIL_ARADDR, prev_addr);
        end
        prev_wait = bus.M_AXIL_ARVALID && !bus.M_AXIL_ARREADY;
        prev_addr = bus.M_AXIL_ARADDR;
        if (bus.user_rsp_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 data=0x%0h, required no response (cycle %0d)",
                     bus.user_rsp_data, cyc);
          end else begin
            check("rsp_data", bus.user_rsp_data, exp_q[0].data);
            check("rsp_resp", 32'(bus.user_rsp_resp), 32'(exp_q[0].resp));
            check("rsp_timeout", 32'(bus.user_rsp_timeout), 32'(exp_q[0].tmo));
            if (bus.user_rsp_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, output int hs);
    int n;
    n = 0;
    hs = -1;
    cur_addr = a;
    bus.user_cmd_addr  = a;
    bus.user_cmd_valid = 1'b1;
    while (hs < 0 && n < 100) begin
      @(negedge clk);
      if (bus.user_cmd_ready) hs = cyc;
      n++;
    end
    if (hs < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL cmd_accept: got no cmd handshake in 100 cycles, required one");
    end
    step();
    bus.user_cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, output int rc, output rsp_t got);
    int n;
    n = 0;
    rc = -1;
    got = '0;
    bus.user_rsp_ready = (hold == 0);
    while (rc < 0 && n < 200) begin
      @(negedge clk);
      if (bus.user_rsp_valid) begin
        rc  = cyc;
        got = '{bus.user_rsp_data, bus.user_rsp_resp, bus.user_rsp_timeout};
      end
      n++;
    end
    if (rc < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL rsp_arrive: got no rsp_valid in 200 cycles, required one");
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      bus.user_rsp_ready = 1'b1;
      @(negedge clk);
    end
    step();
    bus.user_rsp_ready = 1'b0;
  endtask

  task automatic wait_cmd_ready(output int c);
    int n;
    n = 0;
    c = -1;
    while (c < 0 && n < 100) begin
      @(negedge clk);
      if (bus.user_cmd_ready) c = cyc;
      n++;
    end
    if (c < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL cmd_ready_return: got cmd_ready low for 100 cycles, required high");
    end
  endtask

  task automatic run_read(input logic [31:0] a, input int ard, input int rd, input logic [31:0] d,
                          input logic [1:0] r, input int hold, output int hs, output int lat, output rsp_t got);
    int rc;
    ar_delay = ard;
    r_delay  = rd;
    s_rdata  = d;
    s_rresp  = r;
    exp_q.push_back(predict(a, rd, d, r));
    send_cmd(a, hs);
    get_rsp(hold, rc, got);
    lat = rc - hs;
  endtask

  vec_t tbl[4] = '{
    '{32'h0000_0300, 2, 3, 32'h1111_0000, RESP_OKAY,   2},
    '{32'h0000_0304, 0, 9, 32'h2222_0000, RESP_OKAY,   0},
    '{32'h0000_030A, 0, 0, 32'h3333_0000, RESP_OKAY,   1},
    '{32'h0000_0308, 1, 7, 32'h0000_0077, RESP_SLVERR, 0}
  };

  initial begin
    int   hs, lat, c, a0, v0, r0;
    rsp_t got, e;
    rst = 1'b1;
    bus.user_cmd_valid = 1'b0;
    bus.user_cmd_addr  = 32'h0;
    bus.user_rsp_ready = 1'b0;
    ar_delay = 0; r_delay = 0; s_rdata = 32'h0; s_rresp = 2'b00; cur_addr = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.user_cmd_ready), 32'd0);
    check("rst_arvalid", 32'(bus.M_AXIL_ARVALID), 32'd0);
    check("rst_rready", 32'(bus.M_AXIL_RREADY), 32'd0);
    check("rst_rsp_valid", 32'(bus.user_rsp_valid), 32'd0);
    check("rst_rsp_data", bus.user_rsp_data, 32'h0);
    check("rst_rsp_resp", 32'(bus.user_rsp_resp), 32'd0);
    check("rst_rsp_timeout", 32'(bus.user_rsp_timeout), 32'd0);
    check("rst_araddr", bus.M_AXIL_ARADDR, 32'h0);
    check("rst_arprot", 32'(bus.M_AXIL_ARPROT), 32'(PROT));
    step();
    rst = 1'b0;

    // aligned read, immediate slave
    run_read(32'h0000_0010, 0, 0, 32'hDEAD_BEEF, RESP_OKAY, 0, hs, lat, got);
    check("aligned_latency", 32'(lat), 32'd3);
    check("aligned_data", got.data, 32'hDEAD_BEEF);
    check("aligned_resp", 32'(got.resp), 32'd0);
    check("aligned_timeout", 32'(got.tmo), 32'd0);
    @(negedge clk);
    check("aligned_cmd_ready_back", 32'(bus.user_cmd_ready), 32'd1);
    step();

    // AR and response backpressure
    a0 = ar_hs; v0 = av_cycles;
    run_read(32'h0000_0200, 5, 0, 32'hCAFE_0001, RESP_EXOKAY, 4, hs, lat, got);
    check("bp_latency", 32'(lat), 32'd8);
    check("bp_ar_handshakes", 32'(ar_hs - a0), 32'd1);
    check("bp_arvalid_cycles", 32'(av_cycles - v0), 32'd6);
    check("bp_data", got.data, 32'hCAFE_0001);
    check("bp_resp", 32'(got.resp), 32'd1);
    step();

    // misaligned: local error, no bus activity
    a0 = ar_hs; v0 = av_cycles;
    run_read(32'h0000_0013, 0, 0, 32'h5555_5555, RESP_OKAY, 0, hs, lat, got);
    check("mis_latency", 32'(lat), 32'd1);
    check("mis_resp", 32'(got.resp), 32'd2);
    check("mis_data", got.data, 32'h0);
    check("mis_arvalid_cycles", 32'(av_cycles - v0), 32'd0);
    check("mis_ar_handshakes", 32'(ar_hs - a0), 32'd0);
    step();

    // timeout then drain of the late beat
    r0 = r_hs;
    run_read(32'h0000_0100, 0, 20, 32'h1234_5678, RESP_OKAY, 0, hs, lat, got);
    check("tmo_latency", 32'(lat), 32'd11);
    check("tmo_resp", 32'(got.resp), 32'd2);
    check("tmo_flag", 32'(got.tmo), 32'd1);
    check("tmo_data", got.data, 32'h0);
    @(negedge clk);
    check("tmo_cmd_ready_in_drain", 32'(bus.user_cmd_ready), 32'd0);
    wait_cmd_ready(c);
    check("tmo_cmd_ready_cycle", 32'(c - hs), 32'd23);
    check("tmo_drained_beats", 32'(r_hs - r0), 32'd1);
    check("tmo_ready_after_drain", 32'(c - last_r_hs_cyc), 32'd1);
    step();

    // beat arrives in the expiry cycle: real response wins
    r0 = r_hs;
    run_read(32'h0000_0104, 0, 8, 32'hA5A5_A5A5, RESP_DECERR, 0, hs, lat, got);
    check("tie_latency", 32'(lat), 32'd11);
    check("tie_resp", 32'(got.resp), 32'd3);
    check("tie_data", got.data, 32'hA5A5_A5A5);
    check("tie_timeout", 32'(got.tmo), 32'd0);
    @(negedge clk);
    check("tie_no_drain", 32'(bus.user_cmd_ready), 32'd1);
    check("tie_beats", 32'(r_hs - r0), 32'd1);
    step();

    // reset while waiting in R_WAIT
    ar_delay = 0; r_delay = 100;
    send_cmd(32'h0000_0040, hs);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_cmd_ready", 32'(bus.user_cmd_ready), 32'd0);
    check("mid_rst_arvalid", 32'(bus.M_AXIL_ARVALID), 32'd0);
    check("mid_rst_rready", 32'(bus.M_AXIL_RREADY), 32'd0);
    check("mid_rst_rsp_valid", 32'(bus.user_rsp_valid), 32'd0);
    check("mid_rst_rsp_data", bus.user_rsp_data, 32'h0);
    check("mid_rst_rsp_resp", 32'(bus.user_rsp_resp), 32'd0);
    check("mid_rst_araddr", bus.M_AXIL_ARADDR, 32'h0);
    step();
    run_read(32'h0000_0020, 0, 0, 32'h0F0F_1234, RESP_OKAY, 0, hs, lat, got);
    check("post_rst_latency", 32'(lat), 32'd3);
    check("post_rst_data", got.data, 32'h0F0F_1234);
    step();

    // mixed table
    foreach (tbl[i]) begin
      e = predict(tbl[i].a, tbl[i].rd, tbl[i].d, tbl[i].r);
      run_read(tbl[i].a, tbl[i].ard, tbl[i].rd, tbl[i].d, tbl[i].r, tbl[i].hold, hs, lat, got);
      check("tbl_resp", 32'(got.resp), 32'(e.resp));
      check("tbl_timeout", 32'(got.tmo), 32'(e.tmo));
      wait_cmd_ready(c);
      step();
    end

    repeat (5) step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
